// File: rtl/irq_front_pkg.sv
// Shared constants for the interrupt front end and the CPU hardware_interrupt width.
package irq_front_pkg;

    localparam int IRQ_LINES           = 8;
    localparam int IRQ_SYNC_STAGES     = 2;
    localparam int IRQ_DEBOUNCE_CYCLES = 1000000;
    localparam int IRQ_PULSE_CYCLES    = 1;

    // Width needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/irq_line.sv
// One interrupt line: synchroniser, debouncer, rising-edge detect and pulse stretcher.
module irq_line
    import irq_front_pkg::*;
#(
    parameter int SYNC_STAGES     = IRQ_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IRQ_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = IRQ_PULSE_CYCLES
) (
    input  logic clk,
    input  logic clr_n,
    input  logic raw,
    input  logic trig,
    output logic level,
    output logic rise,
    output logic irq
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int PW = cnt_width(PULSE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PC_LOAD  = PW'(PULSE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic [PW-1:0]          pc_q;
    logic [PW-1:0]          pc_d;
    logic                   irq_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any cycle where s agrees with the level restarts the stability count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // trig is the masked rise coming back from the top; a retrigger reloads.
    always_comb begin
        pc_d = pc_q;
        if (trig) begin
            pc_d = PC_LOAD;
        end else if (pc_q != '0) begin
            pc_d = pc_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            pc_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            pc_q    <= pc_d;
            irq_q   <= (pc_d != '0);
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign irq   = irq_q;

endmodule

// File: rtl/irq_front.sv
// Interrupt front end: N independent debounced lines feeding CPU hardware_interrupt,
// with a per-line pulse mask and sticky seen flags for debug LEDs.
module irq_front
    import irq_front_pkg::*;
#(
    parameter int N_LINES         = IRQ_LINES,
    parameter int SYNC_STAGES     = IRQ_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IRQ_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = IRQ_PULSE_CYCLES
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [N_LINES-1:0] raw_in,
    input  logic [N_LINES-1:0] irq_en,
    input  logic               seen_clr,
    output logic [N_LINES-1:0] irq_out,
    output logic [N_LINES-1:0] level_out,
    output logic [N_LINES-1:0] irq_seen
);

    if (DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
        $error("irq_front: need DEBOUNCE_CYCLES>=1, PULSE_CYCLES>=1, SYNC_STAGES>=2");
    end

    logic [N_LINES-1:0] rise;
    logic [N_LINES-1:0] fire;
    logic [N_LINES-1:0] seen_q;

    // A masked rise is dropped outright; the debouncer and seen flags ignore the mask.
    assign fire = rise & irq_en;

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        irq_line #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_CYCLES    (PULSE_CYCLES)
        ) u_line (
            .clk   (clk),
            .clr_n (clr_n),
            .raw   (raw_in[i]),
            .trig  (fire[i]),
            .level (level_out[i]),
            .rise  (rise[i]),
            .irq   (irq_out[i])
        );
    end

    // Set beats clear when a rise lands in the same cycle as seen_clr.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seen_q <= '0;
        end else if (seen_clr) begin
            seen_q <= rise;
        end else begin
            seen_q <= seen_q | rise;
        end
    end

    assign irq_seen = seen_q;

endmodule
